gift_pipe_enc: RTL and testbench

Fully pipelined GIFT-128 encryption core: one 128-bit plaintext block accepted per clock, ciphertext produced after a fixed 40-cycle latency. It is the encrypt-side counterpart of the pipelined decryption datapath and uses the same key/data write style. Each accepted block carries its own round-key state down the pipe, so a key change affects only blocks accepted afterwards. A single output-ready signal applies global backpressure.

---
 rtl/gift_pkg.sv | 26 ++
 rtl/gift_enc_round.sv | 40 ++++
 rtl/gift_pipe_enc.sv | 86 ++++++++
 tb/tb_gift_pipe_enc.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gift_pkg.sv
// rtl/gift_pkg.sv - GIFT-128 constants: S-box, bit permutation, round constants
package gift_pkg;

    localparam int GIFT_BLOCK_W = 128;
    localparam int GIFT_KEY_W   = 128;

    localparam logic [3:0] GIFT_SBOX [16] = '{
        4'h1, 4'ha, 4'h4, 4'hc, 4'h6, 4'hf, 4'h3, 4'h9,
        4'h2, 4'hd, 4'hb, 4'h7, 4'h5, 4'h0, 4'h8, 4'he
    };

    // Output of the 6-bit constant LFSR after r updates, indexed by round r
    localparam logic [5:0] GIFT_RC [1:40] = '{
        6'h01, 6'h03, 6'h07, 6'h0f, 6'h1f, 6'h3e, 6'h3d, 6'h3b, 6'h37, 6'h2f,
        6'h1e, 6'h3c, 6'h39, 6'h33, 6'h27, 6'h0e, 6'h1d, 6'h3a, 6'h35, 6'h2b,
        6'h16, 6'h2c, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0b, 6'h17, 6'h2e,
        6'h1c, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0d, 6'h1b, 6'h36, 6'h2d, 6'h1a
    };

    function automatic logic [6:0] perm_idx(input int i);
        int p;
        p = 4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
        return p[6:0];
    endfunction

endpackage

// File: rtl/gift_enc_round.sv
// rtl/gift_enc_round.sv - one combinational GIFT-128 encryption round plus key update
module gift_enc_round
    import gift_pkg::*;
(
    input  logic [GIFT_BLOCK_W-1:0] state,
    input  logic [GIFT_KEY_W-1:0]   key,
    input  logic [5:0]              rc,
    output logic [GIFT_BLOCK_W-1:0] state_next,
    output logic [GIFT_KEY_W-1:0]   key_next
);

    logic [GIFT_BLOCK_W-1:0] sub;
    logic [GIFT_BLOCK_W-1:0] perm;
    logic [GIFT_BLOCK_W-1:0] ark;

    always_comb begin
        sub  = '0;
        perm = '0;
        for (int n = 0; n < 32; n++) begin
            sub[4*n +: 4] = GIFT_SBOX[state[4*n +: 4]];
        end
        for (int i = 0; i < 128; i++) begin
            perm[perm_idx(i)] = sub[i];
        end
        ark = perm;
        // U = k5||k4 lands on bit 2 of each nibble, V = k1||k0 on bit 1
        for (int i = 0; i < 32; i++) begin
            ark[4*i+2] ^= key[64+i];
            ark[4*i+1] ^= key[i];
        end
        ark[127] ^= 1'b1;
        for (int j = 0; j < 6; j++) begin
            ark[4*j+3] ^= rc[j];
        end
    end

    assign state_next = ark;
    assign key_next   = {key[17:16], key[31:18], key[11:0], key[15:12], key[127:32]};

endmodule

// File: rtl/gift_pipe_enc.sv
// rtl/gift_pipe_enc.sv - fully pipelined GIFT-128 encryptor, one round per stage, global stall
module gift_pipe_enc
    import gift_pkg::*;
#(
    parameter int NUM_ROUNDS = 40
) (
    input  logic                    inClk,
    input  logic                    inRstN,
    input  logic                    inKeyWr,
    input  logic [GIFT_KEY_W-1:0]   inKeyData,
    input  logic                    inDataWr,
    input  logic [GIFT_BLOCK_W-1:0] inDataData,
    output logic                    outReadyIn,
    input  logic                    inOutReady,
    output logic [GIFT_BLOCK_W-1:0] outData,
    output logic                    outValidData
);

    logic [GIFT_KEY_W-1:0]                     key_q;
    logic [GIFT_KEY_W-1:0]                     key_eff;
    logic                                      en;
    logic [NUM_ROUNDS-1:0][GIFT_BLOCK_W-1:0]   st_q;
    logic [NUM_ROUNDS-1:0][GIFT_BLOCK_W-1:0]   st_d;
    logic [NUM_ROUNDS-2:0][GIFT_KEY_W-1:0]     ky_q;
    logic [NUM_ROUNDS-2:0][GIFT_KEY_W-1:0]     ky_d;
    logic [NUM_ROUNDS-1:0]                     vld_q;
    logic [GIFT_KEY_W-1:0]                     last_key_unused;

    assign en           = !vld_q[NUM_ROUNDS-1] || inOutReady;
    assign outReadyIn   = en;
    assign outData      = st_q[NUM_ROUNDS-1];
    assign outValidData = vld_q[NUM_ROUNDS-1];

    // A key written on the same edge as a block applies to that block
    assign key_eff = inKeyWr ? inKeyData : key_q;

    for (genvar r = 0; r < NUM_ROUNDS; r++) begin : g_stage
        logic [GIFT_BLOCK_W-1:0] st_in;
        logic [GIFT_KEY_W-1:0]   ky_in;
        logic [GIFT_KEY_W-1:0]   ky_out;

        if (r == 0) begin : g_first
            assign st_in = inDataData;
            assign ky_in = key_eff;
        end else begin : g_rest
            assign st_in = st_q[r-1];
            assign ky_in = ky_q[r-1];
        end

        if (r == NUM_ROUNDS - 1) begin : g_last
            assign last_key_unused = ky_out;
        end else begin : g_mid
            assign ky_d[r] = ky_out;
        end

        gift_enc_round u_round (
            .state      (st_in),
            .key        (ky_in),
            .rc         (GIFT_RC[r+1]),
            .state_next (st_d[r]),
            .key_next   (ky_out)
        );
    end

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            key_q <= '0;
        end else if (inKeyWr) begin
            key_q <= inKeyData;
        end
    end

    // Bubbles shift with the data; nothing is compressed
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            st_q  <= '0;
            ky_q  <= '0;
            vld_q <= '0;
        end else if (en) begin
            st_q  <= st_d;
            ky_q  <= ky_d;
            vld_q <= {vld_q[NUM_ROUNDS-2:0], inDataWr};
        end
    end

endmodule

// File: tb/tb_gift_pipe_enc.sv
// tb/tb_gift_pipe_enc.sv - self-checking bench for gift_pipe_enc
module tb_gift_pipe_enc;

    logic         inClk;
    logic         inRstN;
    logic         inKeyWr;
    logic [127:0] inKeyData;
    logic         inDataWr;
    logic [127:0] inDataData;
    logic         outReadyIn;
    logic         inOutReady;
    logic [127:0] outData;
    logic         outValidData;

    gift_pipe_enc #(.NUM_ROUNDS(40)) dut (
        .inClk        (inClk),
        .inRstN       (inRstN),
        .inKeyWr      (inKeyWr),
        .inKeyData    (inKeyData),
        .inDataWr     (inDataWr),
        .inDataData   (inDataData),
        .outReadyIn   (outReadyIn),
        .inOutReady   (inOutReady),
        .outData      (outData),
        .outValidData (outValidData)
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t         vecs [2];
    int           pass_cnt;
    int           chk_cnt;
    int           rdy_err;
    int           stall_err;
    int           n_out;
    logic         hold_prev;
    logic [127:0] held;
    logic [127:0] bench_key;
    logic [127:0] exp_q [$];

    function automatic logic [127:0] model_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [63:0]  sbt;
        logic [15:0]  kw [8];
        logic [127:0] s;
        logic [127:0] t;
        logic [5:0]   c;
        logic [15:0]  n6;
        logic [15:0]  n7;
        int           d;
        sbt = 64'he8057bd293f6c4a1;
        for (int i = 0; i < 8; i++) kw[i] = key[16*i +: 16];
        s = pt;
        c = 6'd0;
        for (int r = 0; r < 40; r++) begin
            for (int n = 0; n < 32; n++) s[4*n +: 4] = sbt[int'(s[4*n +: 4]) * 4 +: 4];
            t = '0;
            for (int i = 0; i < 128; i++) begin
                d = 4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
                t[d] = s[i];
            end
            c = {c[4:0], c[5] ^ c[4] ^ 1'b1};
            for (int i = 0; i < 16; i++) begin
                t[4*i+2]      ^= kw[4][i];
                t[4*(i+16)+2] ^= kw[5][i];
                t[4*i+1]      ^= kw[0][i];
                t[4*(i+16)+1] ^= kw[1][i];
            end
            t[127] ^= 1'b1;
            for (int j = 0; j < 6; j++) t[4*j+3] ^= c[j];
            s  = t;
            n7 = {kw[1][1:0], kw[1][15:2]};
            n6 = {kw[0][11:0], kw[0][15:12]};
            for (int i = 0; i < 6; i++) kw[i] = kw[i+2];
            kw[6] = n6;
            kw[7] = n7;
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %032h expected %032h", name, act, exp);
    endtask

    // Sample settled outputs, update scoreboard, then advance one edge
    task automatic step();
        logic [127:0] e;
        #1;
        if (outReadyIn !== (!outValidData || inOutReady)) rdy_err++;
        if (hold_prev && outData !== held) stall_err++;
        hold_prev = outValidData && !inOutReady;
        held      = outData;
        if (outValidData && inOutReady) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL spurious_out: got %032h expected no output", outData);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", outData, e);
            end
        end
        if (inDataWr && (!outValidData || inOutReady))
            exp_q.push_back(model_enc(inKeyWr ? inKeyData : bench_key, inDataData));
        if (inKeyWr) bench_key = inKeyData;
        @(posedge inClk);
        #1;
    endtask

    task automatic drain(input int target, input int bound, output int cycles);
        inDataWr   = 1'b0;
        inKeyWr    = 1'b0;
        inOutReady = 1'b1;
        cycles     = 0;
        while (n_out < target && cycles < bound) begin
            step();
            cycles++;
        end
        check("drain_count", 128'(n_out), 128'(target));
    endtask

    task automatic latency_run(input string name, input logic [127:0] exp_ct);
        int lat;
        lat = 1;
        step();
        inDataWr = 1'b0;
        inKeyWr  = 1'b0;
        while (!outValidData && lat < 100) begin
            step();
            lat++;
        end
        check({name, "_latency"}, 128'(lat), 128'd40);
        check({name, "_ct"}, outData, exp_ct);
        step();
    endtask

    logic [127:0] key_a;
    logic [127:0] key_b;
    int           cyc;
    int           base;

    initial begin
        vecs[0].key = 128'h0;
        vecs[0].pt  = 128'h0;
        vecs[0].ct  = 128'hcd0bd738388ad3f668b15a36ceb6ff92;
        vecs[1].key = 128'hfedcba9876543210fedcba9876543210;
        vecs[1].pt  = 128'hfedcba9876543210fedcba9876543210;
        vecs[1].ct  = 128'h8422241a6dbf5a9346af468409ee0152;

        pass_cnt = 0; chk_cnt = 0; rdy_err = 0; stall_err = 0; n_out = 0;
        hold_prev = 1'b0; held = '0; bench_key = '0;
        inRstN = 1'b0; inKeyWr = 1'b0; inKeyData = '0; inDataWr = 1'b0;
        inDataData = '0; inOutReady = 1'b0;
        repeat (3) @(posedge inClk);
        #1;
        check("rst_valid", 128'(outValidData), 128'd0);
        check("rst_ready", 128'(outReadyIn), 128'd1);
        check("rst_data", outData, 128'h0);
        inRstN = 1'b1;
        inOutReady = 1'b1;
        step();

        // Known-answer vectors, key and block written on the same edge
        for (int v = 0; v < 2; v++) begin
            inKeyWr    = 1'b1;
            inKeyData  = vecs[v].key;
            inDataWr   = 1'b1;
            inDataData = vecs[v].pt;
            latency_run($sformatf("kat%0d", v), vecs[v].ct);
        end

        // 100 back-to-back blocks then drain: last leaves 40 cycles after input stops
        base = n_out;
        for (int i = 0; i < 100; i++) begin
            inDataWr   = 1'b1;
            inDataData = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        drain(base + 100, 200, cyc);
        check("stream_drain_cycles", 128'(cyc), 128'd40);

        // Key change on the same edge as block 5
        key_a = {$urandom, $urandom, $urandom, $urandom};
        key_b = {$urandom, $urandom, $urandom, $urandom};
        inKeyWr = 1'b1; inKeyData = key_a; step();
        inKeyWr = 1'b0;
        base = n_out;
        for (int i = 0; i < 10; i++) begin
            inKeyWr    = (i == 5);
            inKeyData  = key_b;
            inDataWr   = 1'b1;
            inDataData = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        drain(base + 10, 200, cyc);

        // Random backpressure and random input
        stall_err = 0;
        for (int i = 0; i < 400; i++) begin
            inOutReady = ($urandom_range(0, 1) == 1);
            inDataWr   = ($urandom_range(0, 1) == 1);
            inDataData = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        drain(n_out + exp_q.size(), 300, cyc);
        check("bp_queue_empty", 128'(exp_q.size()), 128'd0);
        check("bp_stall_stable", 128'(stall_err), 128'd0);
        check("ready_comb", 128'(rdy_err), 128'd0);

        // Reset with a full pipe and a valid output pending
        for (int i = 0; i < 50; i++) begin
            inDataWr   = 1'b1;
            inDataData = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        inDataWr = 1'b0;
        inRstN   = 1'b0;
        #1;
        check("midrst_valid", 128'(outValidData), 128'd0);
        check("midrst_ready", 128'(outReadyIn), 128'd1);
        check("midrst_data", outData, 128'h0);
        exp_q.delete();
        bench_key = '0;
        hold_prev = 1'b0;
        repeat (3) step();
        inRstN = 1'b1;
        base = n_out;
        repeat (60) step();
        check("no_stale_out", 128'(n_out), 128'(base));
        // Key register was cleared, so a zero block gives the zero-key ciphertext
        inDataWr   = 1'b1;
        inDataData = 128'h0;
        latency_run("post_rst", vecs[0].ct);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
